led_pattern_seq: RTL and testbench

//  Parametrised LED pattern sequencer: next generation of the key-driven LED state block.
//  - Derives its own step tick from an internal prescaler; no divided-counter clock.
//  - Four selectable patterns, debounced step/mode buttons, run/pause control.
//  - Drives the LED bank; exports a 4-bit step index for a 7-segment decoder.
//  - Sits between the top-level KEY/SW pins and LEDG/LEDR/HEX.

---
 rtl/led_seq_pkg.sv | 13 +
 rtl/btn_debounce.sv | 52 +++++
 rtl/led_pattern_seq.sv | 130 +++++++++++++
 tb/tb_led_pattern_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared constants for the LED pattern sequencer: pattern mode codes and index width.
package led_seq_pkg;

  localparam int IDX_W = 4;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SHL = 2'd0;
  localparam mode_t MODE_SHR = 2'd1;
  localparam mode_t MODE_BNC = 2'd2;
  localparam mode_t MODE_CNT = 2'd3;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability down-counter and rising-edge pulse.
// The accepted level moves only after DEB_CYCLES consecutive samples that disagree
// with it; any sample that agrees with the current level restarts the count.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEB_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] stable_cnt;

  // Bring the raw button into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Count remaining disagreeing samples; accept the new level at terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_level  <= 1'b0;
      btn_rise   <= 1'b0;
      stable_cnt <= '0;
    end else begin
      btn_rise <= 1'b0;
      if (sync_q2 == btn_level) begin
        stable_cnt <= CNT_LOAD;
      end else if (stable_cnt == '0) begin
        btn_level  <= sync_q2;
        btn_rise   <= sync_q2;
        stable_cnt <= CNT_LOAD;
      end else begin
        stable_cnt <= stable_cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: prescaler tick, debounced step/mode buttons, pattern FSM.
//
//  mode      | meaning
//  ----------+--------------------------------------------------------------
//  MODE_SHL  | one-hot rotate left, starts at LED 0
//  MODE_SHR  | one-hot rotate right, starts at LED LED_W-1
//  MODE_BNC  | one-hot ping-pong, end LEDs shown once per pass (dir_up tracks heading)
//  MODE_CNT  | binary up-count on the LED bank, index shows the low nibble
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int LED_W      = 8,
  parameter int TICK_DIV   = 16777216,
  parameter int DEB_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_step,
  input  logic             btn_mode,
  input  logic             run_en,
  output logic [LED_W-1:0] leds,
  output logic [IDX_W-1:0] state_idx,
  output logic [1:0]       mode,
  output logic             tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRE_LOAD = PW'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LED_W - 1);
  localparam logic [LED_W-1:0] LED_ONE  = LED_W'(1);

  logic [PW-1:0]    pre_cnt;
  logic             step_press;
  logic             mode_press;
  logic             step_level_unused;
  logic             mode_level_unused;
  logic             advance;
  logic             dir_up;
  logic             dir_nxt;
  mode_t            mode_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [LED_W-1:0] leds_nxt;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_raw   (btn_step),
    .btn_level (step_level_unused),
    .btn_rise  (step_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_raw   (btn_mode),
    .btn_level (mode_level_unused),
    .btn_rise  (mode_press)
  );

  // Prescaler counts down the cycles left until the next tick; frozen while paused.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= PRE_LOAD;
    end else if (run_en) begin
      pre_cnt <= (pre_cnt == '0) ? PRE_LOAD : pre_cnt - PW'(1);
    end
  end

  assign tick    = run_en && (pre_cnt == '0);
  assign advance = tick || step_press;

  // Next pattern state: a mode press re-initialises and swallows any coincident advance.
  always_comb begin
    mode_nxt = mode;
    idx_nxt  = state_idx;
    leds_nxt = leds;
    dir_nxt  = dir_up;
    if (mode_press) begin
      mode_nxt = mode + 2'd1;
      dir_nxt  = 1'b1;
      idx_nxt  = (mode_nxt == MODE_SHR) ? LAST_IDX : '0;
      leds_nxt = (mode_nxt == MODE_CNT) ? '0 : (LED_ONE << idx_nxt);
    end else if (advance) begin
      case (mode)
        MODE_SHL: idx_nxt = (state_idx == LAST_IDX) ? '0 : state_idx + IDX_W'(1);
        MODE_SHR: idx_nxt = (state_idx == '0) ? LAST_IDX : state_idx - IDX_W'(1);
        MODE_BNC: begin
          if (dir_up) begin
            if (state_idx == LAST_IDX) begin
              dir_nxt = 1'b0;
              idx_nxt = LAST_IDX - IDX_W'(1);
            end else begin
              idx_nxt = state_idx + IDX_W'(1);
            end
          end else begin
            if (state_idx == '0) begin
              dir_nxt = 1'b1;
              idx_nxt = IDX_W'(1);
            end else begin
              idx_nxt = state_idx - IDX_W'(1);
            end
          end
        end
        default: begin
          leds_nxt = leds + LED_ONE;
          idx_nxt  = IDX_W'(leds_nxt);
        end
      endcase
      if (mode != MODE_CNT) begin
        leds_nxt = LED_ONE << idx_nxt;
      end
    end
  end

  // Pattern registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode      <= MODE_SHL;
      state_idx <= '0;
      leds      <= LED_ONE;
      dir_up    <= 1'b1;
    end else begin
      mode      <= mode_nxt;
      state_idx <= idx_nxt;
      leds      <= leds_nxt;
      dir_up    <= dir_nxt;
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq with a cycle-level reference built from the pattern rules:
// expected LEDs are a closed-form function of (mode, advances since the mode began).
module tb_led_pattern_seq;

  localparam int LED_W      = 8;
  localparam int TICK_DIV   = 4;
  localparam int DEB_CYCLES = 3;
  // Edges from driving a clean press to the edge that applies it:
  // two synchroniser stages, DEB_CYCLES accepted samples, one cycle for the press pulse.
  localparam int PRESS_LAT  = 2 + DEB_CYCLES + 1;
  // Prescaler phase at which a press driven now lands on a tick edge.
  localparam int COL_PRE    = ((TICK_DIV - 1 - (PRESS_LAT - 1)) % TICK_DIV + TICK_DIV) % TICK_DIV;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             btn_step = 1'b0;
  logic             btn_mode = 1'b0;
  logic             run_en = 1'b0;
  logic [LED_W-1:0] leds;
  logic [3:0]       state_idx;
  logic [1:0]       mode;
  logic             tick;

  int checks = 0;
  int failures = 0;

  // Reference state
  int m_pre, m_k, m_mode, step_cd, mode_cd;
  bit m_tick_prev;
  bit tick_seen;

  always #5 clk = ~clk;

  led_pattern_seq #(.LED_W(LED_W), .TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_step  (btn_step),
    .btn_mode  (btn_mode),
    .run_en    (run_en),
    .leds      (leds),
    .state_idx (state_idx),
    .mode      (mode),
    .tick      (tick)
  );

  function automatic int exp_pos();
    int p;
    int per;
    per = 2 * LED_W - 2;
    case (m_mode)
      0: p = m_k % LED_W;
      1: p = LED_W - 1 - (m_k % LED_W);
      2: begin
        p = m_k % per;
        if (p >= LED_W) p = per - p;
      end
      default: p = (m_k % (1 << LED_W)) % 16;
    endcase
    return p;
  endfunction

  function automatic logic [LED_W-1:0] exp_leds();
    logic [LED_W-1:0] one;
    one = 1;
    if (m_mode == 3) return LED_W'(m_k % (1 << LED_W));
    return one << exp_pos();
  endfunction

  function automatic logic [3:0] exp_idx();
    return 4'(exp_pos());
  endfunction

  function automatic logic exp_tick();
    return run_en && (m_pre == TICK_DIV - 1);
  endfunction

  task automatic model_reset();
    m_pre = 0; m_k = 0; m_mode = 0; step_cd = 0; mode_cd = 0; m_tick_prev = 0;
  endtask

  // One clock: advance the reference on the rising edge, return at the falling edge.
  task automatic clk_cycle();
    bit t, sp, mp;
    @(posedge clk);
    t = run_en && (m_pre == TICK_DIV - 1);
    if (run_en) m_pre = (m_pre == TICK_DIV - 1) ? 0 : m_pre + 1;
    sp = 0; mp = 0;
    if (step_cd > 0) begin step_cd--; sp = (step_cd == 0); end
    if (mode_cd > 0) begin mode_cd--; mp = (mode_cd == 0); end
    if (mp) begin
      m_mode = (m_mode + 1) % 4;
      m_k = 0;
    end else if (t || sp) begin
      m_k++;
    end
    m_tick_prev = t;
    @(negedge clk);
    if (tick) tick_seen = 1;
  endtask

  task automatic press_step();
    btn_step = 1'b1;
    step_cd = PRESS_LAT;
    repeat ($urandom_range(4, 8)) clk_cycle();
    btn_step = 1'b0;
    repeat ($urandom_range(6, 9)) clk_cycle();
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    mode_cd = PRESS_LAT;
    repeat (6) clk_cycle();
    btn_mode = 1'b0;
    repeat (8) clk_cycle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    run_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    checks++; if (leds !== 8'h01) begin failures++; $display("FAIL reset_leds got=%h exp=%h", leds, 8'h01); end
    checks++; if (state_idx !== 4'h0) begin failures++; $display("FAIL reset_idx got=%h exp=%h", state_idx, 4'h0); end
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", mode); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
  endtask

  task automatic test_shl();
    run_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      clk_cycle();
      checks++; if (tick !== exp_tick()) begin failures++; $display("FAIL shl_tick cyc=%0d got=%b exp=%b", c, tick, exp_tick()); end
      checks++; if (leds !== exp_leds()) begin failures++; $display("FAIL shl_leds cyc=%0d got=%h exp=%h", c, leds, exp_leds()); end
      checks++; if (state_idx !== exp_idx()) begin failures++; $display("FAIL shl_idx cyc=%0d got=%h exp=%h", c, state_idx, exp_idx()); end
    end
  endtask

  task automatic test_reset_mid_run();
    for (int c = 0; c < 16 && (m_k % LED_W) != 4; c++) clk_cycle();
    checks++; if (leds !== 8'h10) begin failures++; $display("FAIL midrst_pre got=%h exp=%h", leds, 8'h10); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (leds !== 8'h01) begin failures++; $display("FAIL midrst_leds got=%h exp=%h", leds, 8'h01); end
    checks++; if (state_idx !== 4'h0) begin failures++; $display("FAIL midrst_idx got=%h exp=%h", state_idx, 4'h0); end
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL midrst_mode got=%0d exp=0", mode); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL midrst_tick got=%b exp=0", tick); end
    run_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_debounce();
    int m0;
    m0 = m_mode;
    run_en = 1'b0;
    btn_mode = 1'b1;
    repeat (2) clk_cycle();
    btn_mode = 1'b0;
    repeat (8) clk_cycle();
    checks++; if (mode !== 2'(m0)) begin failures++; $display("FAIL deb_glitch got=%0d exp=%0d", mode, m0); end
    for (int b = 0; b < 5; b++) begin
      btn_mode = 1'b1;
      repeat ($urandom_range(1, 2)) clk_cycle();
      btn_mode = 1'b0;
      repeat ($urandom_range(1, 2)) clk_cycle();
      checks++; if (mode !== 2'(m0)) begin failures++; $display("FAIL deb_bounce b=%0d got=%0d exp=%0d", b, mode, m0); end
    end
    btn_mode = 1'b1;
    mode_cd = PRESS_LAT;
    repeat (10) clk_cycle();
    btn_mode = 1'b0;
    repeat (10) clk_cycle();
    checks++; if (mode !== 2'((m0 + 1) % 4)) begin failures++; $display("FAIL deb_hold got=%0d exp=%0d", mode, (m0 + 1) % 4); end
    checks++; if (leds !== exp_leds()) begin failures++; $display("FAIL deb_init_leds got=%h exp=%h", leds, exp_leds()); end
    checks++; if (state_idx !== exp_idx()) begin failures++; $display("FAIL deb_init_idx got=%h exp=%h", state_idx, exp_idx()); end
  endtask

  task automatic test_bounce_pattern();
    logic [LED_W-1:0] prev;
    run_en = 1'b0;
    for (int i = 0; i < 4 && m_mode != 2; i++) press_mode();
    checks++; if (mode !== 2'd2) begin failures++; $display("FAIL bnc_mode got=%0d exp=2", mode); end
    checks++; if (leds !== 8'h01) begin failures++; $display("FAIL bnc_init got=%h exp=%h", leds, 8'h01); end
    run_en = 1'b1;
    prev = leds;
    for (int c = 0; c < 64; c++) begin
      clk_cycle();
      checks++; if (tick !== exp_tick()) begin failures++; $display("FAIL bnc_tick cyc=%0d got=%b exp=%b", c, tick, exp_tick()); end
      checks++; if (leds !== exp_leds()) begin failures++; $display("FAIL bnc_leds cyc=%0d got=%h exp=%h", c, leds, exp_leds()); end
      checks++; if (state_idx !== exp_idx()) begin failures++; $display("FAIL bnc_idx cyc=%0d got=%h exp=%h", c, state_idx, exp_idx()); end
      if (m_tick_prev) begin
        checks++; if (leds === prev) begin failures++; $display("FAIL bnc_repeat cyc=%0d got=%h prev=%h", c, leds, prev); end
      end
      prev = leds;
    end
  endtask

  task automatic test_count();
    run_en = 1'b0;
    for (int i = 0; i < 4 && m_mode != 3; i++) press_mode();
    checks++; if (mode !== 2'd3) begin failures++; $display("FAIL cnt_mode got=%0d exp=3", mode); end
    checks++; if (leds !== 8'h00) begin failures++; $display("FAIL cnt_init got=%h exp=%h", leds, 8'h00); end
    tick_seen = 0;
    repeat (300) press_step();
    checks++; if (leds !== 8'h2C) begin failures++; $display("FAIL cnt_leds got=%h exp=%h", leds, 8'h2C); end
    checks++; if (state_idx !== 4'hC) begin failures++; $display("FAIL cnt_idx got=%h exp=%h", state_idx, 4'hC); end
    checks++; if (tick_seen !== 1'b0) begin failures++; $display("FAIL cnt_tick_paused got=%b exp=0", tick_seen); end
    run_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      clk_cycle();
      checks++; if (tick !== exp_tick()) begin failures++; $display("FAIL cnt_frozen_tick cyc=%0d got=%b exp=%b", c, tick, exp_tick()); end
      checks++; if (leds !== exp_leds()) begin failures++; $display("FAIL cnt_run_leds cyc=%0d got=%h exp=%h", c, leds, exp_leds()); end
    end
  endtask

  task automatic test_collision();
    int k0;
    run_en = 1'b1;
    for (int c = 0; c < 2 * TICK_DIV && m_pre != COL_PRE; c++) clk_cycle();
    k0 = m_k;
    btn_step = 1'b1;
    step_cd = PRESS_LAT;
    repeat (PRESS_LAT) clk_cycle();
    // one ordinary tick on the way, then the merged tick+press
    checks++; if (leds !== 8'(k0 + 2)) begin failures++; $display("FAIL col_step got=%h exp=%h", leds, 8'(k0 + 2)); end
    btn_step = 1'b0;
    for (int c = 0; c < 10; c++) begin
      clk_cycle();
      checks++; if (leds !== exp_leds()) begin failures++; $display("FAIL col_step_after cyc=%0d got=%h exp=%h", c, leds, exp_leds()); end
    end
    for (int c = 0; c < 2 * TICK_DIV && m_pre != COL_PRE; c++) clk_cycle();
    btn_mode = 1'b1;
    mode_cd = PRESS_LAT;
    repeat (PRESS_LAT) clk_cycle();
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL col_mode got=%0d exp=0", mode); end
    checks++; if (leds !== 8'h01) begin failures++; $display("FAIL col_mode_leds got=%h exp=%h", leds, 8'h01); end
    checks++; if (state_idx !== 4'h0) begin failures++; $display("FAIL col_mode_idx got=%h exp=%h", state_idx, 4'h0); end
    btn_mode = 1'b0;
    for (int c = 0; c < 10; c++) begin
      clk_cycle();
      checks++; if (tick !== exp_tick()) begin failures++; $display("FAIL col_mode_tick cyc=%0d got=%b exp=%b", c, tick, exp_tick()); end
      checks++; if (leds !== exp_leds()) begin failures++; $display("FAIL col_mode_after cyc=%0d got=%h exp=%h", c, leds, exp_leds()); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=still_running exp=finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_shl();
    test_reset_mid_run();
    test_debounce();
    test_bounce_pattern();
    test_count();
    test_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
